// File: rtl/image_bank_ram_if.sv
// Pixel read, pixel write and display-bank control bus of the banked image store.
// master drives requests and data; slave (the RAM) returns read data, write errors and bank status.
interface image_bank_ram_if #(
    parameter int XW    = 8,
    parameter int YW    = 8,
    parameter int BW    = 2,
    parameter int PIX_W = 8
);
    logic             rd_en;
    logic [XW-1:0]    rd_x;
    logic [YW-1:0]    rd_y;
    logic             rd_valid;
    logic [PIX_W-1:0] rd_pixel;
    logic             rd_bit;
    logic [PIX_W-1:0] threshold;

    logic             wr_en;
    logic [BW-1:0]    wr_bank;
    logic [XW-1:0]    wr_x;
    logic [YW-1:0]    wr_y;
    logic [PIX_W-1:0] wr_data;
    logic             wr_err;

    logic             bank_req;
    logic [BW-1:0]    bank_sel;
    logic             frame_start;
    logic [BW-1:0]    bank_active;
    logic             bank_pending;

    modport master (
        output rd_en, rd_x, rd_y, threshold,
        output wr_en, wr_bank, wr_x, wr_y, wr_data,
        output bank_req, bank_sel, frame_start,
        input  rd_valid, rd_pixel, rd_bit, wr_err, bank_active, bank_pending
    );

    modport slave (
        input  rd_en, rd_x, rd_y, threshold,
        input  wr_en, wr_bank, wr_x, wr_y, wr_data,
        input  bank_req, bank_sel, frame_start,
        output rd_valid, rd_pixel, rd_bit, wr_err, bank_active, bank_pending
    );
endinterface

// File: rtl/image_bank_ram.sv
// Banked grayscale frame store with frame-synchronous display-bank switching; 2-cycle read latency.
// No backpressure: one read and one write accepted every cycle, out-of-range writes flagged on wr_err.
module image_bank_ram #(
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 256,
    parameter int PIX_W     = 8,
    parameter int NUM_BANKS = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    image_bank_ram_if.slave bus
);
    localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int DEPTH = NUM_BANKS * IMG_W * IMG_H;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Limits carry one extra bit so a full power-of-two size still fits.
    localparam logic [XW:0] X_LIM = (XW+1)'(IMG_W);
    localparam logic [YW:0] Y_LIM = (YW+1)'(IMG_H);
    localparam logic [BW:0] B_LIM = (BW+1)'(NUM_BANKS);
    localparam logic [BW-1:0] BG_BANK = BW'(NUM_BANKS - 1);

    typedef struct packed {
        logic vld;
        logic inr;
    } rd_stage_t;

    logic [PIX_W-1:0] mem [DEPTH];

    rd_stage_t        s1_q;
    logic [PIX_W-1:0] s1_dat;
    rd_stage_t        s2_q;
    logic [PIX_W-1:0] rd_pixel_q;
    logic             wr_err_q;
    logic [BW-1:0]    bank_active_q;
    logic [BW-1:0]    bank_pend_q;
    logic             bank_pending_q;

    logic             rd_inr;
    logic             wr_inr;
    logic             wr_ok;
    logic [AW-1:0]    rd_addr;
    logic [AW-1:0]    wr_addr;
    logic [BW-1:0]    sel_clamped;

    function automatic logic [AW-1:0] pix_addr(input logic [BW-1:0] b,
                                               input logic [XW-1:0] x,
                                               input logic [YW-1:0] y);
        return AW'(b) * AW'(IMG_W * IMG_H) + AW'(y) * AW'(IMG_W) + AW'(x);
    endfunction

    assign rd_inr  = ({1'b0, bus.rd_x} < X_LIM) && ({1'b0, bus.rd_y} < Y_LIM);
    assign wr_inr  = ({1'b0, bus.wr_bank} < B_LIM) && ({1'b0, bus.wr_x} < X_LIM)
                     && ({1'b0, bus.wr_y} < Y_LIM);
    assign wr_ok   = bus.wr_en && wr_inr;

    // Out-of-range reads are parked on address 0; their data is masked in stage 2.
    assign rd_addr = rd_inr ? pix_addr(bank_active_q, bus.rd_x, bus.rd_y) : '0;
    assign wr_addr = pix_addr(bus.wr_bank, bus.wr_x, bus.wr_y);

    assign sel_clamped = ({1'b0, bus.bank_sel} < B_LIM) ? bus.bank_sel : BG_BANK;

    // Array port kept free of reset; reading before the write lands gives old data on a collision.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= bus.wr_data;
        end
        s1_dat <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            rd_pixel_q <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            s1_q.vld <= bus.rd_en;
            s1_q.inr <= rd_inr;
            s2_q.vld <= s1_q.vld;
            if (s1_q.vld) begin
                s2_q.inr   <= s1_q.inr;
                rd_pixel_q <= s1_q.inr ? s1_dat : '0;
            end
            wr_err_q <= bus.wr_en && !wr_inr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_active_q  <= BG_BANK;
            bank_pend_q    <= BG_BANK;
            bank_pending_q <= 1'b0;
        end else if (bus.bank_req && bus.frame_start) begin
            bank_active_q  <= sel_clamped;
            bank_pending_q <= 1'b0;
        end else if (bus.bank_req) begin
            bank_pend_q    <= sel_clamped;
            bank_pending_q <= 1'b1;
        end else if (bus.frame_start && bank_pending_q) begin
            bank_active_q  <= bank_pend_q;
            bank_pending_q <= 1'b0;
        end
    end

    assign bus.rd_valid     = s2_q.vld;
    assign bus.rd_pixel     = rd_pixel_q;
    assign bus.rd_bit       = s2_q.inr && (rd_pixel_q >= bus.threshold);
    assign bus.wr_err       = wr_err_q;
    assign bus.bank_active  = bank_active_q;
    assign bus.bank_pending = bank_pending_q;
endmodule
